// File: rtl/rgb_fpga_row_scheduler.sv
// Row sequencer for the RGB matrix line engine: fetch a row, start the line
// engine, wait for all PWM sub-frames, blank, advance the row address.
module rgb_fpga_row_scheduler #(
    parameter int ROWS         = 16,
    parameter int ADDR_W       = 4,
    parameter int BLANK_CYCLES = 4,
    parameter int TIMEOUT      = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_row,
    input  logic              fb_rd_valid,
    input  logic [255:0]      fb_rd_data,
    output logic [255:0]      line_data,
    output logic              line_start,
    input  logic              line_rdy,
    output logic [ADDR_W-1:0] row_addr,
    output logic              blank,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int BC_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [BC_W-1:0]   BC_MAX   = BC_W'(BLANK_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        START,
        RUN,
        BLANK
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] row_cnt, row_cnt_nxt;
    logic              armed, armed_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
    logic [BC_W-1:0]   blk_cnt, blk_cnt_nxt;
    logic [ADDR_W-1:0] fb_rd_row_nxt, row_addr_nxt;
    logic              fb_rd_en_nxt, line_start_nxt, blank_nxt;
    logic              frame_done_nxt, timeout_err_nxt;
    logic              capture, go_blank;

    always_comb begin
        state_nxt       = state;
        row_cnt_nxt     = row_cnt;
        armed_nxt       = armed;
        wd_cnt_nxt      = wd_cnt;
        blk_cnt_nxt     = blk_cnt;
        fb_rd_row_nxt   = fb_rd_row;
        row_addr_nxt    = row_addr;
        frame_done_nxt  = 1'b0;
        timeout_err_nxt = timeout_err;
        capture         = 1'b0;
        go_blank        = 1'b0;

        case (state)
            IDLE:      state_nxt = FETCH;
            FETCH:     state_nxt = WAIT_DATA;
            WAIT_DATA: begin
                if (fb_rd_valid) begin
                    capture   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt  = RUN;
                armed_nxt  = 1'b0;
                wd_cnt_nxt = WD_W'(1);
            end
            RUN: begin
                // wd_cnt holds the number of RUN cycles including the current one
                if (wd_cnt == WD_MAX) begin
                    timeout_err_nxt = 1'b1;
                    go_blank        = 1'b1;
                end else if (armed && line_rdy) begin
                    go_blank = 1'b1;
                end else begin
                    wd_cnt_nxt = wd_cnt + 1'b1;
                    if (!line_rdy)
                        armed_nxt = 1'b1;
                end
            end
            BLANK: begin
                if (blk_cnt == BC_MAX)
                    state_nxt = FETCH;
                else
                    blk_cnt_nxt = blk_cnt + 1'b1;
            end
            default:   state_nxt = IDLE;
        endcase

        if (go_blank) begin
            state_nxt   = BLANK;
            blk_cnt_nxt = BC_W'(1);
            if (row_cnt == ROW_LAST) begin
                row_cnt_nxt    = '0;
                frame_done_nxt = 1'b1;
            end else begin
                row_cnt_nxt = row_cnt + 1'b1;
            end
            row_addr_nxt = row_cnt_nxt;
        end

        // Outputs are registered from the next state so they align with it
        fb_rd_en_nxt   = (state_nxt == FETCH);
        line_start_nxt = (state_nxt == START);
        blank_nxt      = !(state_nxt == START || state_nxt == RUN);
        if (state_nxt == FETCH)
            fb_rd_row_nxt = row_cnt_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state       <= IDLE;
            row_cnt     <= '0;
            armed       <= 1'b0;
            wd_cnt      <= '0;
            blk_cnt     <= '0;
            fb_rd_en    <= 1'b0;
            fb_rd_row   <= '0;
            line_start  <= 1'b0;
            row_addr    <= '0;
            blank       <= 1'b1;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            row_cnt     <= row_cnt_nxt;
            armed       <= armed_nxt;
            wd_cnt      <= wd_cnt_nxt;
            blk_cnt     <= blk_cnt_nxt;
            fb_rd_en    <= fb_rd_en_nxt;
            fb_rd_row   <= fb_rd_row_nxt;
            line_start  <= line_start_nxt;
            row_addr    <= row_addr_nxt;
            blank       <= blank_nxt;
            frame_done  <= frame_done_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    // Row data survives a disable so the panel content is not disturbed
    always_ff @(posedge clk) begin
        if (!rst_n)
            line_data <= '0;
        else if (capture && enable)
            line_data <= fb_rd_data;
    end

endmodule

// File: tb/tb_rgb_fpga_row_scheduler.sv
// Randomized scoreboard bench for rgb_fpga_row_scheduler with behavioural
// frame buffer and line engine models.
module tb_rgb_fpga_row_scheduler;

    localparam int ROWS  = 16;
    localparam int AW    = 4;
    localparam int BLK   = 4;
    localparam int TMO   = 100;

    logic          clk = 1'b0;
    logic          rst_n, enable;
    logic          fb_rd_en, fb_rd_valid, line_start, line_rdy;
    logic          blank, frame_done, timeout_err;
    logic [AW-1:0] fb_rd_row, row_addr;
    logic [255:0]  fb_rd_data, line_data;

    rgb_fpga_row_scheduler #(
        .ROWS(ROWS), .ADDR_W(AW), .BLANK_CYCLES(BLK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fb_rd_en(fb_rd_en), .fb_rd_row(fb_rd_row),
        .fb_rd_valid(fb_rd_valid), .fb_rd_data(fb_rd_data),
        .line_data(line_data), .line_start(line_start), .line_rdy(line_rdy),
        .row_addr(row_addr), .blank(blank), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [255:0] d; int at; } dat_t;
    typedef struct { int blank_at; bit to; } end_t;

    int   fetch_q[$];
    dat_t dat_q[$];
    end_t end_q[$];

    int checks = 0, errors = 0;
    int rows_done = 0;
    int exp_fetch_at = 0;
    int cur_row = 0;
    bit in_disp = 0;
    bit sticky_exp = 0;
    int wd_rows = 0;
    bit pending = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Frame buffer: answers each read after 1..4 cycles, plus stray strobes
    initial begin
        int resp_at, nresp;
        logic [255:0] pdata;
        fb_rd_valid = 1'b0;
        fb_rd_data  = '0;
        nresp = 0;
        resp_at = 0;
        pdata = '0;
        forever begin
            @(posedge clk); #1;
            fb_rd_valid = 1'b0;
            if (pending && cyc == resp_at) begin
                dat_t e;
                fb_rd_valid = 1'b1;
                fb_rd_data  = pdata;
                e.d = pdata; e.at = cyc + 1;
                dat_q.push_back(e);
                pending = 0;
            end else if (fb_rd_en && rst_n && enable) begin
                pending = 1;
                resp_at = cyc + int'($urandom_range(1, 4));
                if (nresp == 0) pdata = 256'hFF;
                else for (int i = 0; i < 8; i++) pdata[i*32 +: 32] = $urandom();
                nresp++;
            end else if (!pending && $urandom_range(0, 9) == 0) begin
                fb_rd_valid = 1'b1;
                for (int i = 0; i < 8; i++) fb_rd_data[i*32 +: 32] = $urandom();
            end
        end
    end

    // Line engine: goes busy one cycle after line_start (or three when early), idle again later
    initial begin
        int low_from, high_at, dur, nstart, c;
        bit early;
        end_t e;
        line_rdy = 1'b1;
        low_from = 0; high_at = 0; nstart = 0;
        forever begin
            @(posedge clk); #1;
            if (line_start && rst_n && enable) begin
                c = cyc;
                early = (nstart == 1) || ($urandom_range(0, 3) == 0);
                if (wd_rows > 0) begin
                    dur = 1000;
                    wd_rows--;
                end else begin
                    dur = int'($urandom_range(2, 40));
                end
                low_from = c + 1 + (early ? 2 : 0);
                high_at  = low_from + dur;
                if (high_at >= c + TMO) begin
                    e.blank_at = c + TMO + 1; e.to = 1;
                end else begin
                    e.blank_at = high_at + 1; e.to = 0;
                end
                end_q.push_back(e);
                nstart++;
            end
            line_rdy = !(cyc >= low_from && cyc < high_at);
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n && enable) begin
                if (fb_rd_en) begin
                    chk("fetch_blank", longint'(blank), 1);
                    chk("fetch_time", longint'(cyc), longint'(exp_fetch_at));
                    chk("fetch_during_display", longint'(in_disp), 0);
                    if (fetch_q.size() == 0) begin
                        chk("fetch_unexpected", 1, 0);
                    end else begin
                        cur_row = fetch_q.pop_front();
                        chk("fetch_row", longint'(fb_rd_row), longint'(cur_row));
                    end
                end
                if (line_start) begin
                    chk("start_twice", longint'(in_disp), 0);
                    chk("start_blank", longint'(blank), 0);
                    chk("start_row_addr", longint'(row_addr), longint'(cur_row));
                    if (dat_q.size() == 0) begin
                        chk("start_unexpected", 1, 0);
                    end else begin
                        dat_t d;
                        d = dat_q.pop_front();
                        chk("start_time", longint'(cyc), longint'(d.at));
                        checks++;
                        if (line_data !== d.d) begin
                            errors++;
                            $display("FAIL line_data: got %h expected %h", line_data, d.d);
                        end
                    end
                    in_disp = 1;
                end else if (in_disp && blank) begin
                    if (end_q.size() == 0) begin
                        chk("blank_unexpected", 1, 0);
                    end else begin
                        end_t e;
                        e = end_q.pop_front();
                        chk("blank_time", longint'(cyc), longint'(e.blank_at));
                        if (e.to) sticky_exp = 1;
                    end
                    chk("timeout_err", longint'(timeout_err), longint'(sticky_exp));
                    chk("row_addr_next", longint'(row_addr), longint'((cur_row + 1) % ROWS));
                    chk("frame_done", longint'(frame_done), longint'(cur_row == ROWS - 1));
                    in_disp = 0;
                    exp_fetch_at = cyc + BLK;
                    rows_done++;
                end else begin
                    if (frame_done) chk("frame_done_stray", 1, 0);
                    if (!in_disp) chk("blank_idle", longint'(blank), 1);
                end
            end
        end
    end

    task automatic wait_rows(input int n, input int budget);
        int target;
        target = rows_done + n;
        for (int i = 0; i < budget && rows_done < target; i++) @(posedge clk);
        #1;
        chk("rows_progress", longint'(rows_done >= target), 1);
    endtask

    task automatic fill_fetch();
        fetch_q.delete();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < ROWS; r++) fetch_q.push_back(r);
    endtask

    initial begin
        bit found;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_blank", longint'(blank), 1);
        chk("rst_row_addr", longint'(row_addr), 0);
        chk("rst_line_start", longint'(line_start), 0);
        chk("rst_fb_rd_en", longint'(fb_rd_en), 0);
        chk("rst_timeout_err", longint'(timeout_err), 0);
        chk("rst_line_data", longint'(|line_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal operation across a frame wrap
        fill_fetch();
        exp_fetch_at = cyc + 1;
        enable = 1'b1;
        wait_rows(20, 4000);

        // Watchdog: line engine stays busy for two rows
        wd_rows = 2;
        wait_rows(4, 2000);
        chk("timeout_sticky", longint'(timeout_err), 1);

        // Abort during display of row 5
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(posedge clk); #1;
            if (row_addr == AW'(5) && !blank && !line_start) found = 1;
        end
        chk("abort_reach_row5", longint'(found), 1);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_blank", longint'(blank), 1);
        chk("abort_row_addr", longint'(row_addr), 0);
        chk("abort_timeout_err", longint'(timeout_err), 0);
        chk("abort_frame_done", longint'(frame_done), 0);
        dat_q.delete();
        end_q.delete();
        in_disp = 0;
        sticky_exp = 0;
        pending = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_blank", longint'(blank), 1);
            chk("idle_no_fetch", longint'(fb_rd_en), 0);
        end
        fill_fetch();
        exp_fetch_at = cyc + 1;
        enable = 1'b1;
        wait_rows(3, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
